minmax_reduce_unit: RTL and testbench
=====================================

MINMAX_REDUCE_UNIT -- requirements
Module: minmax_reduce_unit

Interface
REQ-001 Parameter WIDTH, default 32: element width per lane in bits, 8..32.
REQ-002 Parameter LANES, default 1: independent SIMD lanes reduced in parallel, 1..4.
REQ-003 Parameter CNT_W, default 8: width of element count and index, supports up to 2^CNT_W-1 elements.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  request a new reduction (sampled only in IDLE).
REQ-007 op_i  input  2  minmax_op_e: MIN, MAX (signed), MINU, MAXU (unsigned); latched at start.
REQ-008 len_i  input  CNT_W  number of beats to reduce; latched at start.
REQ-009 in_valid_i / in_ready_o  input / output  1 / 1  input beat handshake.
REQ-010 in_data_i  input  LANES*WIDTH  one element per lane, lane 0 in LSBs.
REQ-011 out_valid_o / out_ready_i  output / input  1 / 1  result handshake.
REQ-012 out_data_o  output  LANES*WIDTH  per-lane reduced value.
REQ-013 out_idx_o  output  LANES*CNT_W  per-lane beat index of winning element (present only with MINMAX_ARGIDX_EN).
REQ-014 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, ACCUM, DONE; one-hot or binary encoding at implementer's choice.
REQ-016 IDLE: start_i=1 and len_i>0 -> ACCUM; start_i=1 and len_i=0 -> DONE with identity result; else stay.
REQ-017 On start, each lane accumulator loads identity: MIN 0x7F..F, MAX 0x80..0, MINU all-ones, MAXU 0; count and indices cleared to 0.
REQ-018 in_ready_o=1 exactly when state is ACCUM; beat accepted when in_valid_i & in_ready_o.
REQ-019 Per accepted beat, per lane: acc <= winner(acc, x) using strict compare (x replaces acc only if strictly smaller for MIN/MINU, strictly larger for MAX/MAXU); ties keep earlier element.
REQ-020 Signed compare for MIN/MAX, unsigned for MINU/MAXU, over WIDTH bits per lane; no carry between lanes.
REQ-021 Count increments per accepted beat; accepting beat number len_i moves ACCUM -> DONE.
REQ-022 out_valid_o=1 exactly in DONE; out_data_o valid from the cycle after the last beat is accepted (latency 1).
REQ-023 out_data_o/out_idx_o held stable while out_valid_o=1 and out_ready_i=0.
REQ-024 DONE & out_ready_i -> IDLE next cycle; start_i asserted in the same cycle is ignored.
REQ-025 start_i, op_i, len_i ignored outside IDLE; in_valid_i ignored outside ACCUM.

Reset
REQ-026 rst=1 at a clock edge forces IDLE, clears accumulators, count, indices, out_data_o and out_idx_o to 0, in any state including mid-ACCUM.
REQ-027 After reset: in_ready_o=0, out_valid_o=0, busy_o=0.

Configuration
REQ-028 MINMAX_ARGIDX_EN defined: per-lane index registers and out_idx_o exist; index updates to current count whenever the lane's accumulator updates.
REQ-029 MINMAX_ARGIDX_EN undefined: no index registers, no out_idx_o port; all other behaviour identical.

Structure
REQ-030 Package minmax_pkg holds minmax_op_e, the FSM state enum, and an identity-value function of (op, WIDTH).
REQ-031 Sub-module minmax_lane: one lane's compare-and-select plus accumulator (and index under the macro), instantiated LANES times.

Verification
REQ-032 LANES=1, MIN, len 3, beats {0,15,20} -> out_data_o=0, idx=0, out_valid_o one cycle after third beat.
REQ-033 MAX, beats {-5,10,8} (32-bit) -> out_data_o=10, idx=1; MAXU, beats {0xFFFFFFFF,1} -> 0xFFFFFFFF; MINU same beats -> 1.
REQ-034 start with len 0, op MIN -> DONE next cycle, out_data_o=0x7FFFFFFF, no beats accepted.
REQ-035 LANES=2, WIDTH=16, MIN, beats {0x0005_FFFF, 0x0003_0001} -> out_data_o=0x0003_FFFF (lane1 MIN signed 3, lane0 -1); out_ready_i low 4 cycles -> data held stable.
REQ-036 Tie: MAX, beats {7,7,7} -> idx=0; rst pulsed after 2 of 5 beats -> IDLE, busy_o=0, next start behaves as fresh reduction.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and helpers for the min/max reduction unit.
// The optional argidx feature is controlled by MINMAX_ARGIDX_EN.
package minmax_pkg;

  typedef enum logic [1:0] {
    OP_MIN  = 2'd0,
    OP_MAX  = 2'd1,
    OP_MINU = 2'd2,
    OP_MAXU = 2'd3
  } minmax_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } minmax_state_e;

  // Value that never wins a strict compare, so the first real element always replaces it (or ties it).
  function automatic logic [31:0] identity_value(minmax_op_e op, int unsigned width);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF >> (32 - width);
    case (op)
      OP_MIN:  identity_value = ones >> 1;
      OP_MAX:  identity_value = 32'd1 << (width - 1);
      OP_MINU: identity_value = ones;
      default: identity_value = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/minmax_lane.sv
// One lane: strict compare-and-select into a running accumulator.
// With MINMAX_ARGIDX_EN defined the lane also tracks the winning beat index.
module minmax_lane
  import minmax_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef MINMAX_ARGIDX_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  minmax_op_e       load_op,
  input  minmax_op_e       op,
  input  logic             beat,
  input  logic [WIDTH-1:0] x,
`ifdef MINMAX_ARGIDX_EN
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] idx,
`endif
  output logic [WIDTH-1:0] acc
);

  logic lt_s, gt_s, lt_u, gt_u, upd;

  assign lt_s = $signed(x) < $signed(acc);
  assign gt_s = $signed(x) > $signed(acc);
  assign lt_u = x < acc;
  assign gt_u = x > acc;

  always_comb begin
    upd = 1'b0;
    case (op)
      OP_MIN:  upd = lt_s;
      OP_MAX:  upd = gt_s;
      OP_MINU: upd = lt_u;
      default: upd = gt_u;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= WIDTH'(identity_value(load_op, WIDTH));
    end else if (beat && upd) begin
      acc <= x;
    end
  end

`ifdef MINMAX_ARGIDX_EN
  always_ff @(posedge clk) begin
    if (rst || load) begin
      idx <= '0;
    end else if (beat && upd) begin
      idx <= cnt;
    end
  end
`endif

endmodule

// File: rtl/minmax_reduce_unit.sv
// Multi-lane streaming min/max reduction with a result handshake.
// Define MINMAX_ARGIDX_EN to add per-lane winning-index outputs (out_idx_o).
module minmax_reduce_unit
  import minmax_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  minmax_op_e             op_i,
  input  logic [CNT_W-1:0]       len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*WIDTH-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*WIDTH-1:0] out_data_o,
`ifdef MINMAX_ARGIDX_EN
  output logic [LANES*CNT_W-1:0] out_idx_o,
`endif
  output logic                   busy_o
);

  minmax_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, len_q;
  minmax_op_e       op_q;
  logic             start_acc, accept, last_beat;

  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign accept    = (state_q == ST_ACCUM) && in_valid_i;
  assign last_beat = accept && ((cnt_q + CNT_W'(1)) == len_q);

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (last_beat) state_d = ST_DONE;
      ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      op_q    <= OP_MIN;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        cnt_q <= '0;
        len_q <= len_i;
        op_q  <= op_i;
      end else if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Lanes are fully independent; the op used at load time comes straight from the port.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    minmax_lane #(
      .WIDTH(WIDTH)
`ifdef MINMAX_ARGIDX_EN
      , .CNT_W(CNT_W)
`endif
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (start_acc),
      .load_op(op_i),
      .op     (op_q),
      .beat   (accept),
      .x      (in_data_i[l*WIDTH +: WIDTH]),
`ifdef MINMAX_ARGIDX_EN
      .cnt    (cnt_q),
      .idx    (out_idx_o[l*CNT_W +: CNT_W]),
`endif
      .acc    (out_data_o[l*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_minmax_reduce_unit.sv
// Directed bench for minmax_reduce_unit: a 1x32 instance and a 2x16 instance.
// Index checks are compiled in only when MINMAX_ARGIDX_EN is defined.
module tb_minmax_reduce_unit;
  import minmax_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: WIDTH=32, LANES=1
  logic        a_start, a_valid, a_ready, a_out_valid, a_out_ready, a_busy;
  minmax_op_e  a_op;
  logic [7:0]  a_len;
  logic [31:0] a_data, a_out;
`ifdef MINMAX_ARGIDX_EN
  logic [7:0]  a_idx;
`endif

  // Instance B: WIDTH=16, LANES=2
  logic        b_start, b_valid, b_ready, b_out_valid, b_out_ready, b_busy;
  minmax_op_e  b_op;
  logic [7:0]  b_len;
  logic [31:0] b_data, b_out;
`ifdef MINMAX_ARGIDX_EN
  logic [15:0] b_idx;
`endif

  minmax_reduce_unit u_a (
    .clk(clk), .rst(rst), .start_i(a_start), .op_i(a_op), .len_i(a_len),
    .in_valid_i(a_valid), .in_ready_o(a_ready), .in_data_i(a_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out),
`ifdef MINMAX_ARGIDX_EN
    .out_idx_o(a_idx),
`endif
    .busy_o(a_busy)
  );

  minmax_reduce_unit #(.WIDTH(16), .LANES(2), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .start_i(b_start), .op_i(b_op), .len_i(b_len),
    .in_valid_i(b_valid), .in_ready_o(b_ready), .in_data_i(b_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out),
`ifdef MINMAX_ARGIDX_EN
    .out_idx_o(b_idx),
`endif
    .busy_o(b_busy)
  );

  typedef struct {
    minmax_op_e        op;
    logic [7:0]        len;
    logic [3:0][31:0]  beats;
    logic [31:0]       exp_data;
    logic [7:0]        exp_idx;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(minmax_op_e op, logic [7:0] len, logic [31:0] b0, logic [31:0] b1,
                              logic [31:0] b2, logic [31:0] b3, logic [31:0] ed, logic [7:0] ei);
    vec_t v;
    v.op = op; v.len = len;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.exp_data = ed; v.exp_idx = ei;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one reduction on instance A; bubble inserts an idle cycle with garbage data before each beat.
  task automatic applyStimulus(input vec_t v, input bit bubble, input string tag);
    a_start = 1'b1; a_op = v.op; a_len = v.len;
    tick();
    a_start = 1'b0; a_op = OP_MAXU; a_len = 8'hFF;
    checkOutput({tag, ".in_ready"}, 64'(a_ready), 64'd1);
    checkOutput({tag, ".valid_early"}, 64'(a_out_valid), 64'd0);
    for (int b = 0; b < int'(v.len); b++) begin
      if (bubble) begin
        a_valid = 1'b0; a_data = 32'h8000_0000;
        tick();
      end
      a_valid = 1'b1; a_data = v.beats[b];
      tick();
    end
    a_valid = 1'b0;
    checkOutput({tag, ".out_valid"}, 64'(a_out_valid), 64'd1);
    checkOutput({tag, ".data"}, 64'(a_out), 64'(v.exp_data));
    checkOutput({tag, ".ready_done"}, 64'(a_ready), 64'd0);
`ifdef MINMAX_ARGIDX_EN
    checkOutput({tag, ".idx"}, 64'(a_idx), 64'(v.exp_idx));
`endif
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checkOutput({tag, ".released"}, 64'(a_out_valid), 64'd0);
    checkOutput({tag, ".idle"}, 64'(a_busy), 64'd0);
  endtask

  task automatic run_b(input minmax_op_e op, input logic [31:0] b0, input logic [31:0] b1);
    b_start = 1'b1; b_op = op; b_len = 8'd2;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1; b_data = b0;
    tick();
    b_data = b1;
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(OP_MIN,  8'd3, 32'd0, 32'd15, 32'd20, 32'd0, 32'd0, 8'd0);
    vecs[1] = mk(OP_MAX,  8'd3, 32'hFFFF_FFFB, 32'd10, 32'd8, 32'd0, 32'd10, 8'd1);
    vecs[2] = mk(OP_MAXU, 8'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 8'd0);
    vecs[3] = mk(OP_MINU, 8'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 8'd1);
    vecs[4] = mk(OP_MAX,  8'd3, 32'd7, 32'd7, 32'd7, 32'd0, 32'd7, 8'd0);
    vecs[5] = mk(OP_MIN,  8'd4, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFD, 8'd1);
    vecs[6] = mk(OP_MINU, 8'd4, 32'd5, 32'h8000_0000, 32'd3, 32'd3, 32'd3, 8'd2);
    vecs[7] = mk(OP_MAX,  8'd1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 8'd0);
    vecs[8] = mk(OP_MAXU, 8'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0);

    rst = 1'b1;
    a_start = 1'b0; a_op = OP_MIN; a_len = '0; a_valid = 1'b0; a_data = '0; a_out_ready = 1'b0;
    b_start = 1'b0; b_op = OP_MIN; b_len = '0; b_valid = 1'b0; b_data = '0; b_out_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst.busy", 64'(a_busy), 64'd0);
    checkOutput("rst.in_ready", 64'(a_ready), 64'd0);
    checkOutput("rst.out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("rst.data", 64'(a_out), 64'd0);
    checkOutput("rst.b_busy", 64'(b_busy), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], bit'(i % 2), $sformatf("vec%0d", i));
    end

    // Zero-length request completes at once with the identity; start during DONE is ignored.
    a_start = 1'b1; a_op = OP_MIN; a_len = 8'd0;
    tick();
    a_op = OP_MAX; a_len = 8'd3;
    checkOutput("len0.out_valid", 64'(a_out_valid), 64'd1);
    checkOutput("len0.data", 64'(a_out), 64'h7FFF_FFFF);
    checkOutput("len0.in_ready", 64'(a_ready), 64'd0);
    tick();
    checkOutput("len0.hold", 64'(a_out_valid), 64'd1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0; a_start = 1'b0;
    checkOutput("len0.start_ignored", 64'(a_busy), 64'd0);
    checkOutput("len0.no_accum", 64'(a_ready), 64'd0);

    // Reset in the middle of an accumulation.
    a_start = 1'b1; a_op = OP_MAX; a_len = 8'd5;
    tick();
    a_start = 1'b0;
    a_valid = 1'b1; a_data = 32'd100;
    tick();
    a_data = 32'd200;
    tick();
    a_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst.busy", 64'(a_busy), 64'd0);
    checkOutput("midrst.in_ready", 64'(a_ready), 64'd0);
    checkOutput("midrst.out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("midrst.data", 64'(a_out), 64'd0);
    applyStimulus(mk(OP_MAX, 8'd2, 32'hFFFF_FFF8, 32'hFFFF_FFF7, 32'd0, 32'd0, 32'hFFFF_FFF8, 8'd0),
                  1'b0, "fresh");

    // Two 16-bit lanes: signed MIN, then hold the result under backpressure.
    run_b(OP_MIN, 32'h0005_FFFF, 32'h0003_0001);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("lanes.hold_valid%0d", c), 64'(b_out_valid), 64'd1);
      checkOutput($sformatf("lanes.hold_data%0d", c), 64'(b_out), 64'h0003_FFFF);
`ifdef MINMAX_ARGIDX_EN
      checkOutput($sformatf("lanes.hold_idx%0d", c), 64'(b_idx), 64'h0100);
`endif
      tick();
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    checkOutput("lanes.released", 64'(b_out_valid), 64'd0);

    run_b(OP_MAXU, 32'h8000_0001, 32'h7FFF_FFFF);
    checkOutput("lanes.maxu", 64'(b_out), 64'h8000_FFFF);
`ifdef MINMAX_ARGIDX_EN
    checkOutput("lanes.maxu_idx", 64'(b_idx), 64'h0001);
`endif
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    run_b(OP_MAX, 32'hFFFF_0002, 32'h0001_8000);
    checkOutput("lanes.max_signed", 64'(b_out), 64'h0001_0002);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
